// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage load/store.
// Optional ack timeout with BusErr reporting is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InstrReqF,
  input  logic [31:0] PCF,
  input  logic        FlushF,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic [31:0] ReadDataM,
  output logic        DataDoneM,
  output logic        StallF,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        BusErr
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t state_reg, state_next;
  logic   drop_reg;
  logic   busy, timeout, done, grant_data, grant_fetch;

  assign busy        = (state_reg == FETCH) || (state_reg == DATA);
  assign grant_data  = (state_reg == IDLE) && MemReqM;
  assign grant_fetch = (state_reg == IDLE) && !MemReqM && InstrReqF && !FlushF;
  assign done        = busy && (mem_ack || timeout);

  assign StallF = InstrReqF & ~InstrValidF;
  assign StallM = MemReqM & ~DataDoneM;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_reg;

  // Counter holds the number of completed wait cycles; the last one trips the timeout.
  assign timeout = busy && !mem_ack && (cnt_reg == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= 8'd0;
      BusErr  <= 1'b0;
    end else begin
      BusErr <= timeout;
      if (state_reg == IDLE)
        cnt_reg <= 8'd0;
      else if (busy && !mem_ack)
        cnt_reg <= cnt_reg + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
  assign BusErr  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_data)
          state_next = DATA;
        else if (grant_fetch)
          state_next = FETCH;
      end
      FETCH, DATA: begin
        if (done)
          state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      InstrF      <= 32'd0;
      ReadDataM   <= 32'd0;
      InstrValidF <= 1'b0;
      DataDoneM   <= 1'b0;
      drop_reg    <= 1'b0;
    end else begin
      InstrValidF <= 1'b0;
      DataDoneM   <= 1'b0;
      case (state_reg)
        IDLE: begin
          drop_reg <= 1'b0;
          if (grant_data) begin
            mem_req   <= 1'b1;
            mem_addr  <= ALUResultM;
            mem_we    <= MemWriteM;
            mem_wdata <= WriteDataM;
          end else if (grant_fetch) begin
            mem_req   <= 1'b1;
            mem_addr  <= PCF;
            mem_we    <= 1'b0;
            mem_wdata <= 32'd0;
          end
        end
        FETCH: begin
          if (FlushF)
            drop_reg <= 1'b1;
          if (done) begin
            mem_req <= 1'b0;
            // A flush in the ack cycle itself must also kill the response.
            if (!drop_reg && !FlushF) begin
              InstrValidF <= 1'b1;
              InstrF      <= timeout ? 32'd0 : mem_rdata;
            end
          end
        end
        DATA: begin
          if (done) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            DataDoneM <= 1'b1;
            if (!mem_we)
              ReadDataM <= timeout ? 32'd0 : mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
